ethernet_fmc_core_ctrl: RTL and testbench

Multi-channel core power-up/power-down sequencer for the Ethernet FMC tile: for each of `NUM_CORES` cores it synchronises an enable request, turns the core clock enable on, holds reset for a programmable delay and then releases it. On disable it asserts reset first and gates the clock only after a drain delay. A fixed-priority grant admits at most one channel per cycle into power-up, which limits inrush.

---
 rtl/ethernet_fmc_pkg.sv | 25 ++
 rtl/ethernet_fmc_core_ctrl_chan.sv | 95 +++++++++
 rtl/ethernet_fmc_core_ctrl.sv | 61 ++++++
 tb/tb_ethernet_fmc_core_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ethernet_fmc_pkg.sv
// Shared types and default timing for the Ethernet FMC core power sequencer.
package ethernet_fmc_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      CLK_ON = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } core_ctrl_state_t;

   localparam int DEFAULT_NUM_CORES     = 4;
   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_RELEASE_DELAY = 8;
   localparam int DEFAULT_GATE_DELAY    = 4;

   // Counter only has to reach max(delay)-1, so clog2 of the larger delay suffices.
   function automatic int cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ethernet_fmc_core_ctrl_chan.sv
// One core channel: enable synchroniser, power sequencing FSM and delay counter.
module ethernet_fmc_core_ctrl_chan
   import ethernet_fmc_pkg::*;
#(
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int RELEASE_DELAY = DEFAULT_RELEASE_DELAY,
   parameter int GATE_DELAY    = DEFAULT_GATE_DELAY,
   parameter int CNT_W         = cnt_width(RELEASE_DELAY, GATE_DELAY)
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic core_en_i,
   input  logic grant_i,
   output logic req_o,
   output logic active_next_o,
   output logic core_clk_en_o,
   output logic core_reset_n_o,
   output logic core_running_o
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   en_s;
   core_ctrl_state_t       state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   clk_en_reg;
   logic                   run_reg;

   assign en_s = sync_reg[SYNC_STAGES-1];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         OFF: begin
            if (en_s && grant_i) begin
               state_next = CLK_ON;
               cnt_next   = '0;
            end
         end
         CLK_ON: begin
            // A dropped request aborts straight into the drain sequence.
            if (!en_s) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_W'(RELEASE_DELAY - 1)) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RUN: begin
            if (!en_s) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
         end
         DRAIN: begin
            if (cnt_reg == CNT_W'(GATE_DELAY - 1)) begin
               state_next = OFF;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = OFF;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_reg   <= '0;
         state_reg  <= OFF;
         cnt_reg    <= '0;
         clk_en_reg <= 1'b0;
         run_reg    <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[SYNC_STAGES-2:0], core_en_i};
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         clk_en_reg <= (state_next != OFF);
         run_reg    <= (state_next == RUN);
      end
   end

   assign req_o          = (state_reg == OFF) && en_s;
   assign active_next_o  = (state_next == CLK_ON) || (state_next == DRAIN);
   assign core_clk_en_o  = clk_en_reg;
   // Reset release and the running flag are both exactly "in RUN".
   assign core_reset_n_o = run_reg;
   assign core_running_o = run_reg;

endmodule

// File: rtl/ethernet_fmc_core_ctrl.sv
// Multi-core power sequencer: per-channel FSMs, fixed-priority power-up grant, busy flag.
module ethernet_fmc_core_ctrl
   import ethernet_fmc_pkg::*;
#(
   parameter int NUM_CORES     = DEFAULT_NUM_CORES,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int RELEASE_DELAY = DEFAULT_RELEASE_DELAY,
   parameter int GATE_DELAY    = DEFAULT_GATE_DELAY
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [NUM_CORES-1:0] core_en_i,
   output logic [NUM_CORES-1:0] core_clk_en_o,
   output logic [NUM_CORES-1:0] core_reset_n_o,
   output logic [NUM_CORES-1:0] core_running_o,
   output logic                 busy_o
);

   localparam int CNT_W = cnt_width(RELEASE_DELAY, GATE_DELAY);

   logic [NUM_CORES-1:0] req;
   logic [NUM_CORES-1:0] grant;
   logic [NUM_CORES-1:0] active_next;
   logic                 busy_reg;

   // Isolate the lowest set request bit: one power-up admission per cycle.
   assign grant = req & (~req + NUM_CORES'(1));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORES; gi++) begin : g_chan
         ethernet_fmc_core_ctrl_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .RELEASE_DELAY (RELEASE_DELAY),
            .GATE_DELAY    (GATE_DELAY),
            .CNT_W         (CNT_W)
         ) u_chan (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .core_en_i      (core_en_i[gi]),
            .grant_i        (grant[gi]),
            .req_o          (req[gi]),
            .active_next_o  (active_next[gi]),
            .core_clk_en_o  (core_clk_en_o[gi]),
            .core_reset_n_o (core_reset_n_o[gi]),
            .core_running_o (core_running_o[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_reg <= 1'b0;
      end else begin
         busy_reg <= |active_next;
      end
   end

   assign busy_o = busy_reg;

endmodule

// File: tb/tb_ethernet_fmc_core_ctrl.sv
// Directed scoreboard bench for the core power sequencer (4 cores, sync 2, release 8, gate 4).
module tb_ethernet_fmc_core_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [3:0] core_en_i;
   logic [3:0] core_clk_en_o;
   logic [3:0] core_reset_n_o;
   logic [3:0] core_running_o;
   logic       busy_o;

   ethernet_fmc_core_ctrl #(
      .NUM_CORES     (4),
      .SYNC_STAGES   (2),
      .RELEASE_DELAY (8),
      .GATE_DELAY    (4)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .core_en_i      (core_en_i),
      .core_clk_en_o  (core_clk_en_o),
      .core_reset_n_o (core_reset_n_o),
      .core_running_o (core_running_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string      tag;
      int         cyc;
      logic [3:0] clk_en;
      logic [3:0] rst_n;
      logic [3:0] run;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   cycle  = 0;
   int   t0     = 0;
   int   checks = 0;
   int   errors = 0;

   // Expected outputs after edge t0+off, where edge t0 is the next edge after stimulus.
   task automatic expect_at(input string tag, input int off, input logic [3:0] ce,
                            input logic [3:0] rn, input logic [3:0] rr, input logic b);
      exp_t e;
      e.tag = tag; e.cyc = t0 + off; e.clk_en = ce; e.rst_n = rn; e.run = rr; e.busy = b;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      logic [12:0] obs, req;
      @(posedge clk_i);
      #1;
      cycle++;
      checks++;
      assert ((core_reset_n_o & ~core_clk_en_o) === 4'b0000) else begin
         errors++;
         $error("FAIL rst_without_clk cyc=%0d clk_en=%b reset_n=%b required no reset_n without clk_en",
                cycle, core_clk_en_o, core_reset_n_o);
      end
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         e   = sb.pop_front();
         obs = {core_clk_en_o, core_reset_n_o, core_running_o, busy_o};
         req = {e.clk_en, e.rst_n, e.run, e.busy};
         checks++;
         assert (e.cyc == cycle && obs === req) else begin
            errors++;
            $error("FAIL %s cyc=%0d/%0d observed clk_en=%b rst_n=%b run=%b busy=%b required clk_en=%b rst_n=%b run=%b busy=%b",
                   e.tag, cycle, e.cyc, obs[12:9], obs[8:5], obs[4:1], obs[0],
                   e.clk_en, e.rst_n, e.run, e.busy);
         end
         $display("check %-16s cyc=%0d clk_en=%b rst_n=%b run=%b busy=%b",
                  e.tag, cycle, obs[12:9], obs[8:5], obs[4:1], obs[0]);
      end
   endtask

   task automatic run_to(input int off);
      while (cycle < t0 + off) tick();
   endtask

   initial begin
      reset_i   = 1'b1;
      core_en_i = 4'b0000;
      t0 = cycle + 1;
      expect_at("reset_state", 2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      run_to(2);

      // Single power-up on channel 0
      reset_i   = 1'b0;
      core_en_i = 4'b0001;
      t0 = cycle + 1;
      expect_at("up_sync",     1,  4'b0000, 4'b0000, 4'b0000, 1'b0);
      expect_at("up_clk_on",   2,  4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("up_pre_rel",  9,  4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("up_release",  10, 4'b0001, 4'b0001, 4'b0001, 1'b0);
      run_to(12);

      // Power-down from RUN
      core_en_i = 4'b0000;
      t0 = cycle + 1;
      expect_at("dn_hold",     1, 4'b0001, 4'b0001, 4'b0001, 1'b0);
      expect_at("dn_reset",    2, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("dn_pre_gate", 5, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("dn_gate",     6, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      run_to(8);

      // Contention: all four requested together
      core_en_i = 4'b1111;
      t0 = cycle + 1;
      expect_at("ct_ch0",      2,  4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("ct_ch1",      3,  4'b0011, 4'b0000, 4'b0000, 1'b1);
      expect_at("ct_ch2",      4,  4'b0111, 4'b0000, 4'b0000, 1'b1);
      expect_at("ct_ch3",      5,  4'b1111, 4'b0000, 4'b0000, 1'b1);
      expect_at("ct_rel0",     10, 4'b1111, 4'b0001, 4'b0001, 1'b1);
      expect_at("ct_rel1",     11, 4'b1111, 4'b0011, 4'b0011, 1'b1);
      expect_at("ct_rel2",     12, 4'b1111, 4'b0111, 4'b0111, 1'b1);
      expect_at("ct_rel3",     13, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      run_to(14);

      core_en_i = 4'b0000;
      t0 = cycle + 1;
      expect_at("ct_all_drain", 2, 4'b1111, 4'b0000, 4'b0000, 1'b1);
      expect_at("ct_all_off",   6, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      run_to(8);

      // Abort three cycles into CLK_ON
      core_en_i = 4'b0001;
      t0 = cycle + 1;
      expect_at("ab_clk_on",   2, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      run_to(2);
      core_en_i = 4'b0000;
      t0 = cycle + 1;
      expect_at("ab_still_on", 1, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("ab_drain",    2, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      run_to(3);
      // Re-request while draining: drain finishes, then a full restart
      core_en_i = 4'b0001;
      expect_at("ab_pre_gate", 5,  4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("ab_gated",    6,  4'b0000, 4'b0000, 4'b0000, 1'b0);
      expect_at("rr_clk_on",   7,  4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("rr_pre_rel",  14, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      expect_at("rr_release",  15, 4'b0001, 4'b0001, 4'b0001, 1'b0);
      run_to(16);

      // Build channel 1 in RUN and channel 2 in DRAIN, then reset
      core_en_i = 4'b0110;
      t0 = cycle + 1;
      expect_at("mx_ch1_on",   2,  4'b0011, 4'b0000, 4'b0000, 1'b1);
      expect_at("mx_ch2_on",   3,  4'b0111, 4'b0000, 4'b0000, 1'b1);
      expect_at("mx_ch0_off",  6,  4'b0110, 4'b0000, 4'b0000, 1'b1);
      expect_at("mx_run",      11, 4'b0110, 4'b0110, 4'b0110, 1'b0);
      run_to(12);
      core_en_i = 4'b0010;
      t0 = cycle + 1;
      expect_at("mx_ch2_drain", 2, 4'b0110, 4'b0010, 4'b0010, 1'b1);
      run_to(2);
      reset_i = 1'b1;
      t0 = cycle + 1;
      expect_at("rst_mid",     0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      expect_at("rst_hold",    1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      run_to(1);
      reset_i = 1'b0;
      t0 = cycle + 1;
      expect_at("rs_sync",     1,  4'b0000, 4'b0000, 4'b0000, 1'b0);
      expect_at("rs_clk_on",   2,  4'b0010, 4'b0000, 4'b0000, 1'b1);
      expect_at("rs_release",  10, 4'b0010, 4'b0010, 4'b0010, 1'b0);
      run_to(12);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed %0d pending required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
